// File: rtl/ir_queue_if.sv
// Handshake bundle between instruction memory, the instruction queue and decode.
// slave modport: the queue itself (accepts from IM, presents to decode).
// master modport: the surrounding fetch/decode logic (or a testbench) driving the queue.
interface ir_queue_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
);
   // IM -> queue
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_instr;
   logic [PC_W-1:0]   in_pc;

   // queue -> decode
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [PC_W-1:0]   out_pc;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/ir_queue.sv
// Instruction queue: DEPTH-entry FWFT buffer of {instr, pc} between IM and decode, with flush.
// Latency: entry pushed at edge N is on the outputs after edge N; zero with IR_QUEUE_BYPASS_EN on an empty queue.
// Backpressure: in_ready = not full (independent of out_ready); out_* held stable until out_ready, flush or reset.
module ir_queue #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   ir_queue_if.slave        bus,
   output logic [CNT_W-1:0] count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Storage; contents are don't-care out of reset, validity is tracked by r_count.
   logic [DATA_W-1:0] r_mem_instr [DEPTH];
   logic [PC_W-1:0]   r_mem_pc    [DEPTH];

   // Pointers wrap naturally at DEPTH (power of two); full/empty come from r_count only.
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_in_ready;
   logic              w_stored;
   logic              w_out_valid;
   logic              w_push;
   logic              w_wr_en;
   logic              w_rd_adv;
   logic [DATA_W-1:0] w_out_instr;
   logic [PC_W-1:0]   w_out_pc;

   // Full blocks pushes even when decode pops in the same cycle, so in_ready never
   // sees out_ready combinationally.
   assign w_in_ready = (r_count != FULL_CNT);
   assign w_stored   = (r_count != '0);
   assign w_push     = bus.in_valid & w_in_ready;

`ifdef IR_QUEUE_BYPASS_EN
   logic w_byp;
   logic w_byp_take;

   // Empty queue with a live fetch: present the incoming word directly to decode.
   assign w_byp       = ~w_stored & bus.in_valid & ~flush;
   // Decode takes the forwarded word this cycle, so it never lands in storage.
   assign w_byp_take  = w_byp & bus.out_ready;
   assign w_out_valid = w_stored | w_byp;
   assign w_wr_en     = w_push & ~w_byp_take & ~flush;
`else
   assign w_out_valid = w_stored;
   assign w_wr_en     = w_push & ~flush;
`endif

   // Only stored entries advance the read pointer; a forwarded word never occupied a slot.
   assign w_rd_adv = w_stored & bus.out_ready & ~flush;

   // Head selection: stored head, forwarded input, or zero when nothing is valid.
   always_comb begin
      w_out_instr = '0;
      w_out_pc    = '0;
      if (w_stored) begin
         w_out_instr = r_mem_instr[r_rd_ptr];
         w_out_pc    = r_mem_pc[r_rd_ptr];
      end
`ifdef IR_QUEUE_BYPASS_EN
      else if (w_byp) begin
         w_out_instr = bus.in_instr;
         w_out_pc    = bus.in_pc;
      end
`endif
   end

   // Storage write at the tail; no reset needed since r_count qualifies every read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem_instr[r_wr_ptr] <= bus.in_instr;
         r_mem_pc[r_wr_ptr]    <= bus.in_pc;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_wr_en, w_rd_adv})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_instr = w_out_instr;
   assign bus.out_pc    = w_out_pc;
   assign count         = r_count;

endmodule

// File: tb/tb_ir_queue.sv
// Testbench for ir_queue: directed scenarios followed by randomized traffic.
// A queue-based reference model is updated at each rising edge by the driver;
// a negedge monitor compares every DUT output against the model's head.
module tb_ir_queue;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic             clk   = 1'b0;
   logic             rst   = 1'b0;
   logic             flush = 1'b0;
   logic [CNT_W-1:0] count;

   ir_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

   ir_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .bus  (bus.slave),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t exp_q[$];
   int   mdl_cnt = 0;
   int   errors  = 0;
   int   checks  = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whether the model expects same-cycle forwarding of the current input.
   function automatic bit byp_now();
`ifdef IR_QUEUE_BYPASS_EN
      return (mdl_cnt == 0) && bus.in_valid && !flush;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: advance by one rising edge using the inputs the bench is driving.
   task automatic model_edge();
      bit push, pop, byp;
      if (!rst) begin
         exp_q.delete();
         mdl_cnt = 0;
      end else if (flush) begin
         exp_q.delete();
         mdl_cnt = 0;
      end else begin
         byp  = byp_now();
         pop  = bus.out_ready && (mdl_cnt != 0);
         push = bus.in_valid && (mdl_cnt != DEPTH) && !(byp && bus.out_ready);
         if (push) exp_q.push_back(ent_t'({bus.in_instr, bus.in_pc}));
         mdl_cnt = mdl_cnt + int'(push) - int'(pop);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model.
   task automatic step(bit v, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl);
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      flush         = fl;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Monitor: compare all outputs to the model mid-cycle; retire the head on a pop.
   always @(negedge clk) begin
      bit   byp, v;
      ent_t head;
      if (rst) begin
         byp  = byp_now();
         v    = (mdl_cnt != 0) || byp;
         head = '0;
         if (byp) head = ent_t'({bus.in_instr, bus.in_pc});
         else if (mdl_cnt != 0 && exp_q.size() > 0) head = exp_q[0];
         chk("count",     64'(count),         64'(mdl_cnt));
         chk("in_ready",  64'(bus.in_ready),  64'(mdl_cnt != DEPTH));
         chk("out_valid", 64'(bus.out_valid), 64'(v));
         chk("out_instr", 64'(bus.out_instr), 64'(head.instr));
         chk("out_pc",    64'(bus.out_pc),    64'(head.pc));
         if (v && bus.out_ready && !flush && !byp && exp_q.size() > 0)
            void'(exp_q.pop_front());
      end
   end

   initial begin
      bit          hold;
      bit          v;
      logic [31:0] hi, hp;

      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      chk("rst_count",     64'(count),         64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
      chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

      // Single push, visible one cycle later.
      step(1, 32'h20080005, 32'h00400000, 0, 0);
      chk("first_count", 64'(count), 64'd1);
      chk("first_instr", 64'(bus.out_instr), 64'h20080005);
      chk("first_pc",    64'(bus.out_pc),    64'h00400000);
      step(0, '0, '0, 0, 0);
      step(0, '0, '0, 1, 0);
      chk("first_drained", 64'(count), 64'd0);

      // Fill to full, try a fifth push, then drain in order.
      for (int k = 1; k <= 4; k++) step(1, 32'(k), 32'h00400100 + 32'(4 * k), 0, 0);
      chk("full_count",    64'(count),        64'd4);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      step(1, 32'h5, 32'h00400200, 0, 0);
      chk("full_ignored", 64'(count), 64'd4);
      step(1, 32'h5, 32'h00400200, 1, 0);
      chk("full_pop_no_push", 64'(count), 64'd3);
      for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 0);
      chk("drain_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_instr", 64'(bus.out_instr), 64'd0);

      // Steady push+pop at occupancy 2, pointers lapping several times.
      step(1, 32'hA0, 32'h00400300, 0, 0);
      step(1, 32'hA1, 32'h00400304, 0, 0);
      for (int k = 2; k < 12; k++) step(1, 32'hA0 + 32'(k), 32'h00400300 + 32'(4 * k), 1, 0);
      chk("stream_count", 64'(count), 64'd2);
      step(0, '0, '0, 1, 0);
      step(0, '0, '0, 1, 0);

      // Flush beats a simultaneous push and pop.
      for (int k = 0; k < 3; k++) step(1, 32'hB0 + 32'(k), 32'h00400400 + 32'(4 * k), 0, 0);
      chk("pre_flush_count", 64'(count), 64'd3);
      step(1, 32'hDEADBEEF, 32'h00400500, 1, 1);
      chk("flush_count",     64'(count),         64'd0);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
      step(1, 32'hC0, 32'h00400600, 0, 0);
      step(0, '0, '0, 1, 0);

      // Asynchronous reset between edges.
      step(1, 32'hD0, 32'h00400700, 0, 0);
      step(1, 32'hD1, 32'h00400704, 0, 0);
      bus.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_count",     64'(count),         64'd0);
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_out_instr", 64'(bus.out_instr), 64'd0);
      exp_q.delete();
      mdl_cnt = 0;
      @(posedge clk);
      #1 rst = 1'b1;

`ifdef IR_QUEUE_BYPASS_EN
      // Zero-latency forwarding into a ready decode stage.
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h8C090004;
      bus.in_pc     = 32'h00400800;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      #1;
      chk("byp_valid", 64'(bus.out_valid), 64'd1);
      chk("byp_instr", 64'(bus.out_instr), 64'h8C090004);
      @(posedge clk);
      model_edge();
      #1;
      chk("byp_count", 64'(count), 64'd0);
      step(0, '0, '0, 0, 0);
`endif

      // Randomized traffic; producer holds its word until accepted.
      hold = 1'b0;
      v    = 1'b0;
      hi   = '0;
      hp   = '0;
      for (int i = 0; i < 400; i++) begin
         bit fl, ordy, acc;
         if (!hold) begin
            v  = ($urandom_range(0, 3) != 0);
            hi = $urandom;
            hp = 32'h00401000 + 32'(4 * i);
         end
         fl   = ($urandom_range(0, 29) == 0);
         ordy = ($urandom_range(0, 2) != 0);
         acc  = v && (mdl_cnt != DEPTH) && !fl;
         hold = v && !acc && !fl;
         step(v, hi, hp, ordy, fl);
      end

      for (int k = 0; k < DEPTH + 1; k++) step(0, '0, '0, 1, 0);
      chk("final_count", 64'(count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
